// File: rtl/key_led_ctrl.sv
// Multi-channel key-to-LED controller: per-channel key sync, debounce and press pulse,
// plus a per-channel LED mode (follow / toggle / toggle-blink) with a shared blink timer.
module key_led_ctrl #(
  parameter int unsigned CH_NUM       = 2,
  parameter int unsigned DB_CYCLES    = 1_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [CH_NUM-1:0]     key,
  input  logic [2*CH_NUM-1:0]   mode,
  output logic [CH_NUM-1:0]     key_press,
  output logic [CH_NUM-1:0]     led
);

  localparam int unsigned DbW = $clog2(DB_CYCLES);
  localparam int unsigned BlW = $clog2(BLINK_CYCLES);
  localparam logic [DbW-1:0] DbMax = DbW'(DB_CYCLES - 1);
  localparam logic [BlW-1:0] BlMax = BlW'(BLINK_CYCLES - 1);

  logic [CH_NUM-1:0] r_sync1, r_sync2;
  logic [CH_NUM-1:0] r_stable, r_stable_d1;
  logic [CH_NUM-1:0] r_press, r_tgl, r_led;
  logic [DbW-1:0]    r_db_cnt [CH_NUM];
  logic [BlW-1:0]    r_bl_cnt;
  logic              r_phase;

  logic [CH_NUM-1:0] w_stable_d, w_fall, w_tgl_d, w_led_d;
  logic [DbW-1:0]    w_db_cnt_d [CH_NUM];
  logic [1:0]        w_mode_ch  [CH_NUM];
  logic              w_bl_wrap;

  // Debounce: a differing level must be seen DB_CYCLES samples in a row; any match restarts.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      w_db_cnt_d[i] = '0;
      w_stable_d[i] = r_stable[i];
      if (r_sync2[i] != r_stable[i]) begin
        if (r_db_cnt[i] == DbMax) begin
          w_stable_d[i] = r_sync2[i];
        end else begin
          w_db_cnt_d[i] = r_db_cnt[i] + DbW'(1);
        end
      end
    end
  end

  assign w_bl_wrap = (r_bl_cnt == BlMax);

  // tgl flips on the same edge the press pulse rises, so led follows one cycle after the pulse.
  always_comb begin
    w_fall  = r_stable_d1 & ~r_stable;
    w_tgl_d = r_tgl;
    w_led_d = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_mode_ch[i] = mode[2*i +: 2];
      if (w_fall[i] && (w_mode_ch[i] == 2'd1 || w_mode_ch[i] == 2'd2)) begin
        w_tgl_d[i] = ~r_tgl[i];
      end
      unique case (w_mode_ch[i])
        2'd0:    w_led_d[i] = ~r_stable[i];
        2'd1:    w_led_d[i] = r_tgl[i];
        2'd2:    w_led_d[i] = r_tgl[i] & r_phase;
        default: w_led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1     <= '1;
      r_sync2     <= '1;
      r_stable    <= '1;
      r_stable_d1 <= '1;
      r_press     <= '0;
      r_tgl       <= '0;
      r_led       <= '0;
      r_bl_cnt    <= '0;
      r_phase     <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1     <= key;
      r_sync2     <= r_sync1;
      r_stable    <= w_stable_d;
      r_stable_d1 <= r_stable;
      r_press     <= w_fall;
      r_tgl       <= w_tgl_d;
      r_led       <= w_led_d;
      r_bl_cnt    <= w_bl_wrap ? '0 : r_bl_cnt + BlW'(1);
      r_phase     <= w_bl_wrap ? ~r_phase : r_phase;
      for (int i = 0; i < CH_NUM; i++) begin
        r_db_cnt[i] <= w_db_cnt_d[i];
      end
    end
  end

  assign key_press = r_press;
  assign led       = r_led;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed bench for key_led_ctrl: vector table for debounce/follow/toggle,
// hand sequences for blink, mode switch and asynchronous reset.
module tb_key_led_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [1:0] key;
  logic [3:0] mode;
  logic [1:0] key_press;
  logic [1:0] led;

  int checks = 0;
  int failures = 0;
  int press_cnt [2] = '{0, 0};

  key_led_ctrl #(
    .CH_NUM      (2),
    .DB_CYCLES   (8),
    .BLINK_CYCLES(4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key      (key),
    .mode     (mode),
    .key_press(key_press),
    .led      (led)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0] key;
    logic [3:0] mode;
    int         ticks;
    logic [1:0] exp_kp;
    logic [1:0] exp_led;
    int         exp_n0;
    int         exp_n1;
  } vec_t;

  vec_t vecs [28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample #1 after the edge and tally press pulses.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    for (int c = 0; c < 2; c++) press_cnt[c] += int'(key_press[c]);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int   bad;
    int   first;
    int   n;
    int   idx;
    logic s [24];
    logic ok;

    // ch0 follow, clean press then release
    vecs[0]  = '{2'b10, 4'b0000, 10, 2'b00, 2'b00, 0, 0};
    vecs[1]  = '{2'b10, 4'b0000,  1, 2'b01, 2'b01, 1, 0};
    vecs[2]  = '{2'b10, 4'b0000,  1, 2'b00, 2'b01, 1, 0};
    vecs[3]  = '{2'b10, 4'b0000, 18, 2'b00, 2'b01, 1, 0};
    vecs[4]  = '{2'b11, 4'b0000, 10, 2'b00, 2'b01, 1, 0};
    vecs[5]  = '{2'b11, 4'b0000,  1, 2'b00, 2'b00, 1, 0};
    vecs[6]  = '{2'b11, 4'b0000, 10, 2'b00, 2'b00, 1, 0};
    // ch0 bounce 5 low / 2 high / 5 low / 3 high, then held low
    vecs[7]  = '{2'b10, 4'b0000,  5, 2'b00, 2'b00, 1, 0};
    vecs[8]  = '{2'b11, 4'b0000,  2, 2'b00, 2'b00, 1, 0};
    vecs[9]  = '{2'b10, 4'b0000,  5, 2'b00, 2'b00, 1, 0};
    vecs[10] = '{2'b11, 4'b0000,  3, 2'b00, 2'b00, 1, 0};
    vecs[11] = '{2'b10, 4'b0000, 10, 2'b00, 2'b00, 1, 0};
    vecs[12] = '{2'b10, 4'b0000,  1, 2'b01, 2'b01, 2, 0};
    vecs[13] = '{2'b10, 4'b0000,  9, 2'b00, 2'b01, 2, 0};
    vecs[14] = '{2'b11, 4'b0000, 11, 2'b00, 2'b00, 2, 0};
    vecs[15] = '{2'b11, 4'b0000,  5, 2'b00, 2'b00, 2, 0};
    // ch1 toggle, three presses
    vecs[16] = '{2'b01, 4'b0100, 11, 2'b10, 2'b00, 2, 1};
    vecs[17] = '{2'b01, 4'b0100,  1, 2'b00, 2'b10, 2, 1};
    vecs[18] = '{2'b01, 4'b0100,  8, 2'b00, 2'b10, 2, 1};
    vecs[19] = '{2'b11, 4'b0100, 20, 2'b00, 2'b10, 2, 1};
    vecs[20] = '{2'b01, 4'b0100, 11, 2'b10, 2'b10, 2, 2};
    vecs[21] = '{2'b01, 4'b0100,  1, 2'b00, 2'b00, 2, 2};
    vecs[22] = '{2'b01, 4'b0100,  8, 2'b00, 2'b00, 2, 2};
    vecs[23] = '{2'b11, 4'b0100, 20, 2'b00, 2'b00, 2, 2};
    vecs[24] = '{2'b01, 4'b0100, 11, 2'b10, 2'b00, 2, 3};
    vecs[25] = '{2'b01, 4'b0100,  1, 2'b00, 2'b10, 2, 3};
    vecs[26] = '{2'b01, 4'b0100,  8, 2'b00, 2'b10, 2, 3};
    vecs[27] = '{2'b11, 4'b0100, 20, 2'b00, 2'b10, 2, 3};

    // Reset state, checked before any clock edge
    sys_rst_n = 1'b1;
    key       = 2'b11;
    mode      = 4'b0000;
    #1 sys_rst_n = 1'b0;
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_kp", 32'(key_press), 32'h0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    bad = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (led !== 2'b00 || key_press !== 2'b00) bad++;
    end
    chk("idle_100", 32'(bad), 32'h0);

    for (int v = 0; v < 28; v++) begin
      key  = vecs[v].key;
      mode = vecs[v].mode;
      ticks(vecs[v].ticks);
      chk($sformatf("vec%0d_kp", v), 32'(key_press), 32'(vecs[v].exp_kp));
      chk($sformatf("vec%0d_led", v), 32'(led), 32'(vecs[v].exp_led));
      chk($sformatf("vec%0d_n0", v), 32'(press_cnt[0]), 32'(vecs[v].exp_n0));
      chk($sformatf("vec%0d_n1", v), 32'(press_cnt[1]), 32'(vecs[v].exp_n1));
    end

    // ch0 toggle-blink
    mode = 4'b0110;
    key  = 2'b10;
    ticks(11);
    chk("blink_press", 32'(key_press), 32'h1);
    tick();
    for (int t = 0; t < 24; t++) begin
      tick();
      s[t] = led[0];
    end
    chk("blink_ch1_steady", 32'(led[1]), 32'h1);
    idx = 0;
    for (int t = 8; t >= 1; t--) if (s[t] != s[t-1]) idx = t;
    chk("blink_edge_found", 32'(idx != 0), 32'h1);
    if (idx != 0) begin
      ok = 1'b1;
      for (int j = 1; j < 4; j++) if (s[idx+j] != s[idx] || s[idx+4+j] != s[idx+4]) ok = 1'b0;
      chk("blink_half_period", 32'(ok), 32'h1);
      chk("blink_flip", 32'(s[idx+4] != s[idx]), 32'h1);
      chk("blink_period", 32'(s[idx+8] == s[idx]), 32'h1);
    end
    key = 2'b11;
    ticks(15);
    key = 2'b10;
    ticks(12);
    bad = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (led[0] !== 1'b0) bad++;
    end
    chk("blink_off_steady", 32'(bad), 32'h0);
    key = 2'b11;
    ticks(15);
    key = 2'b10;
    ticks(12);
    mode = 4'b0101;
    tick();
    chk("mode_sw_led", 32'(led[0]), 32'h1);
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (led[0] !== 1'b1) bad++;
    end
    chk("mode_sw_steady", 32'(bad), 32'h0);

    // Asynchronous reset mid-debounce with tgl0 = 1
    key = 2'b11;
    ticks(15);
    chk("pre_rst_led", 32'(led), 32'h3);
    key = 2'b10;
    ticks(5);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'h0);
    chk("async_rst_kp", 32'(key_press), 32'h0);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    first = 0;
    n     = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (key_press[0] === 1'b1) begin
        n++;
        if (first == 0) first = t;
      end
    end
    chk("post_rst_presses", 32'(n), 32'h1);
    // Edge 1 after release loads the synchroniser; pulse lands 10 or 11 edges out.
    chk("post_rst_latency", 32'(first >= 10 && first <= 11), 32'h1);
    chk("post_rst_led", 32'(led), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
